// File: rtl/chip8_exec.sv
// chip8_exec: execute stage of the CHIP-8 core.
// Owns V0-VF, I and the return stack, drops stale fetch beats by address and
// sends one-cycle PC redirects back to fetch for control flow.
// Optional feature macro: CHIP8_SHIFT_VY_EN (8XY6/8XYE shift VY instead of VX).
module chip8_exec #(
  parameter logic [11:0] RESET_PC    = 12'h000,
  parameter int          STACK_DEPTH = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_instr,
  input  logic [11:0] in_pc,
  output logic        redirect_valid,
  output logic [11:0] redirect_pc,
  output logic [11:0] i_reg,
  output logic        illegal,
  output logic        halted,
  input  logic [3:0]  dbg_sel,
  output logic [7:0]  dbg_data
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam int SP_W  = IDX_W + 1;

  typedef enum logic [0:0] {ST_RUN = 1'b0, ST_HALT = 1'b1} state_t;

  state_t            state_r, state_next_s;
  logic [7:0]        v_r [16];
  logic [11:0]       i_r;
  logic [SP_W-1:0]   sp_r;
  logic [11:0]       stack_r [STACK_DEPTH];
  logic [11:0]       exp_pc_r, exp_pc_next_s;
  logic              redirect_valid_r, illegal_r;
  logic [11:0]       redirect_pc_r;

  logic [3:0]  op_s, x_s, y_s, z_s;
  logic [7:0]  nn_s, vx_s, vy_s, shift_src_s;
  logic [11:0] nnn_s, pc_plus2_s;
  logic [8:0]  sum_s;
  logic [IDX_W-1:0] push_idx_s, top_idx_s;
  logic        accept_s, exec_s, in_ready_s;
  logic        vx_we_s, vf_we_s, i_we_s, push_s, pop_s, redir_s, illegal_s;
  logic [7:0]  vx_wd_s, vf_wd_s;
  logic [11:0] redir_pc_s;

  assign op_s        = in_instr[15:12];
  assign x_s         = in_instr[11:8];
  assign y_s         = in_instr[7:4];
  assign z_s         = in_instr[3:0];
  assign nn_s        = in_instr[7:0];
  assign nnn_s       = in_instr[11:0];
  assign vx_s        = v_r[x_s];
  assign vy_s        = v_r[y_s];
  assign pc_plus2_s  = in_pc + 12'd2;
  assign sum_s       = {1'b0, vx_s} + {1'b0, vy_s};
  assign push_idx_s  = sp_r[IDX_W-1:0];
  assign top_idx_s   = sp_r[IDX_W-1:0] - IDX_W'(1'b1);
`ifdef CHIP8_SHIFT_VY_EN
  assign shift_src_s = vy_s;
`else
  assign shift_src_s = vx_s;
`endif

  // Handshake: only accept while running and out of reset; execute only the expected address.
  assign in_ready_s  = rst_n & (state_r == ST_RUN);
  assign accept_s    = in_valid & in_ready_s;
  assign exec_s      = accept_s & (in_pc == exp_pc_r);

  assign in_ready       = in_ready_s;
  assign redirect_valid = redirect_valid_r;
  assign redirect_pc    = redirect_pc_r;
  assign illegal        = illegal_r;
  assign halted         = (state_r == ST_HALT);
  assign i_reg          = i_r;
  assign dbg_data       = v_r[dbg_sel];

  // Decode the accepted instruction into next-state and register-update controls.
  always_comb begin
    state_next_s  = state_r;
    exp_pc_next_s = exp_pc_r;
    vx_we_s = 1'b0;  vx_wd_s = 8'h00;
    vf_we_s = 1'b0;  vf_wd_s = 8'h00;
    i_we_s  = 1'b0;  push_s  = 1'b0;  pop_s = 1'b0;
    redir_s = 1'b0;  redir_pc_s = redirect_pc_r;  illegal_s = 1'b0;
    if (exec_s) begin
      exp_pc_next_s = pc_plus2_s;
      case (op_s)
        4'h0: begin
          if (nnn_s == 12'h0EE) begin
            if (sp_r == {SP_W{1'b0}}) begin
              state_next_s  = ST_HALT;
              exp_pc_next_s = exp_pc_r;
            end else begin
              pop_s         = 1'b1;
              redir_s       = 1'b1;
              redir_pc_s    = stack_r[top_idx_s];
              exp_pc_next_s = stack_r[top_idx_s];
            end
          end else begin
            illegal_s = 1'b1;
          end
        end
        4'h1: begin
          redir_s = 1'b1;  redir_pc_s = nnn_s;  exp_pc_next_s = nnn_s;
        end
        4'h2: begin
          if (sp_r == SP_W'(STACK_DEPTH)) begin
            state_next_s  = ST_HALT;
            exp_pc_next_s = exp_pc_r;
          end else begin
            push_s = 1'b1;  redir_s = 1'b1;  redir_pc_s = nnn_s;  exp_pc_next_s = nnn_s;
          end
        end
        4'h3: if (vx_s == nn_s) exp_pc_next_s = in_pc + 12'd4; else exp_pc_next_s = pc_plus2_s;
        4'h4: if (vx_s != nn_s) exp_pc_next_s = in_pc + 12'd4; else exp_pc_next_s = pc_plus2_s;
        4'h5: begin
          if (z_s != 4'h0) illegal_s = 1'b1;
          else if (vx_s == vy_s) exp_pc_next_s = in_pc + 12'd4;
          else exp_pc_next_s = pc_plus2_s;
        end
        4'h9: begin
          if (z_s != 4'h0) illegal_s = 1'b1;
          else if (vx_s != vy_s) exp_pc_next_s = in_pc + 12'd4;
          else exp_pc_next_s = pc_plus2_s;
        end
        4'h6: begin vx_we_s = 1'b1; vx_wd_s = nn_s; end
        4'h7: begin vx_we_s = 1'b1; vx_wd_s = vx_s + nn_s; end
        4'hA: i_we_s = 1'b1;
        4'hB: begin
          redir_s       = 1'b1;
          redir_pc_s    = nnn_s + {4'h0, v_r[0]};
          exp_pc_next_s = nnn_s + {4'h0, v_r[0]};
        end
        4'h8: begin
          vx_we_s = 1'b1;
          case (z_s)
            4'h0: vx_wd_s = vy_s;
            4'h1: vx_wd_s = vx_s | vy_s;
            4'h2: vx_wd_s = vx_s & vy_s;
            4'h3: vx_wd_s = vx_s ^ vy_s;
            4'h4: begin vx_wd_s = sum_s[7:0];   vf_we_s = 1'b1; vf_wd_s = {7'h00, sum_s[8]}; end
            4'h5: begin vx_wd_s = vx_s - vy_s;  vf_we_s = 1'b1; vf_wd_s = {7'h00, vx_s >= vy_s}; end
            4'h6: begin vx_wd_s = {1'b0, shift_src_s[7:1]}; vf_we_s = 1'b1; vf_wd_s = {7'h00, shift_src_s[0]}; end
            4'h7: begin vx_wd_s = vy_s - vx_s;  vf_we_s = 1'b1; vf_wd_s = {7'h00, vy_s >= vx_s}; end
            4'hE: begin vx_wd_s = {shift_src_s[6:0], 1'b0}; vf_we_s = 1'b1; vf_wd_s = {7'h00, shift_src_s[7]}; end
            default: begin vx_we_s = 1'b0; illegal_s = 1'b1; end
          endcase
        end
        default: illegal_s = 1'b1;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // State, architectural registers, stack and registered pulse outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r          <= ST_RUN;
      i_r              <= 12'h000;
      sp_r             <= {SP_W{1'b0}};
      exp_pc_r         <= RESET_PC;
      redirect_valid_r <= 1'b0;
      redirect_pc_r    <= 12'h000;
      illegal_r        <= 1'b0;
      for (int k = 0; k < 16; k++) v_r[k] <= 8'h00;
      for (int k = 0; k < STACK_DEPTH; k++) stack_r[k] <= 12'h000;
    end else begin
      state_r          <= state_next_s;
      exp_pc_r         <= exp_pc_next_s;
      redirect_valid_r <= redir_s;
      redirect_pc_r    <= redir_pc_s;
      illegal_r        <= illegal_s;
      if (i_we_s) i_r <= nnn_s;
      if (vx_we_s) v_r[x_s] <= vx_wd_s;
      // Flag write comes last so it wins when X = F.
      if (vf_we_s) v_r[15] <= vf_wd_s;
      if (push_s) begin
        stack_r[push_idx_s] <= pc_plus2_s;
        sp_r <= sp_r + SP_W'(1'b1);
      end else if (pop_s) begin
        sp_r <= sp_r - SP_W'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_chip8_exec.sv
// Self-checking bench for chip8_exec (RESET_PC = 0x200, STACK_DEPTH = 2).
module tb_chip8_exec;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, redirect_valid, illegal, halted;
  logic [15:0] in_instr;
  logic [11:0] in_pc, redirect_pc, i_reg;
  logic [3:0]  dbg_sel;
  logic [7:0]  dbg_data;

  int tests = 0;
  int fails = 0;

  chip8_exec #(.RESET_PC(12'h200), .STACK_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .i_reg(i_reg), .illegal(illegal),
    .halted(halted), .dbg_sel(dbg_sel), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        vld;
    logic [11:0] pc;
    logic [15:0] instr;
    logic        rv;
    logic [11:0] rpc;
    logic        ill;
    logic [3:0]  sel;
    logic [7:0]  val;
  } vec_t;

  typedef struct {
    logic        rv;
    logic [11:0] rpc;
    logic        ill;
  } exp_t;

  vec_t vecs[$];
  exp_t sb_q[$];
  logic [11:0] last_rpc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  function automatic vec_t mk(input logic vld, input logic [11:0] pc, input logic [15:0] instr,
                              input logic rv, input logic [11:0] rpc, input logic ill,
                              input logic [3:0] sel, input logic [7:0] val);
    vec_t v;
    v.vld = vld; v.pc = pc; v.instr = instr; v.rv = rv; v.rpc = rpc;
    v.ill = ill; v.sel = sel; v.val = val;
    return v;
  endfunction

  // One beat (or idle cycle): push expectation, clock, pop and compare.
  task automatic apply(input vec_t v, input int idx);
    exp_t e;
    in_valid = v.vld; in_pc = v.pc; in_instr = v.instr; dbg_sel = v.sel;
    e.rv = v.rv; e.rpc = v.rpc; e.ill = v.ill;
    sb_q.push_back(e);
    if (v.vld) chk($sformatf("ready[%0d]", idx), {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    e = sb_q.pop_front();
    if (e.rv) last_rpc = e.rpc;
    chk($sformatf("redir_v[%0d]", idx), {31'd0, redirect_valid}, {31'd0, e.rv});
    chk($sformatf("redir_pc[%0d]", idx), {20'd0, redirect_pc}, {20'd0, last_rpc});
    chk($sformatf("illegal[%0d]", idx), {31'd0, illegal}, {31'd0, e.ill});
    chk($sformatf("V%0h[%0d]", v.sel, idx), {24'd0, dbg_data}, {24'd0, v.val});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("ready_in_reset", {31'd0, in_ready}, 32'd0);
    rst_n = 1'b1;
    in_valid = 1'b0;
    last_rpc = 12'h000;
  endtask

  initial begin
    logic [7:0] shr_v3, shr_vf;
`ifdef CHIP8_SHIFT_VY_EN
    shr_v3 = 8'h01; shr_vf = 8'h00;
`else
    shr_v3 = 8'h40; shr_vf = 8'h01;
`endif
    //                vld  pc       instr     rv  rpc      ill  sel   val
    vecs.push_back(mk(1'b1, 12'h200, 16'h6A12, 1'b0, 12'h000, 1'b0, 4'hA, 8'h12));
    vecs.push_back(mk(1'b1, 12'h202, 16'h7AF0, 1'b0, 12'h000, 1'b0, 4'hA, 8'h02));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b0, 4'hF, 8'h00));
    vecs.push_back(mk(1'b1, 12'h204, 16'h61FF, 1'b0, 12'h000, 1'b0, 4'h1, 8'hFF));
    vecs.push_back(mk(1'b1, 12'h206, 16'h6201, 1'b0, 12'h000, 1'b0, 4'h2, 8'h01));
    vecs.push_back(mk(1'b1, 12'h208, 16'h8124, 1'b0, 12'h000, 1'b0, 4'h1, 8'h00));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b0, 4'hF, 8'h01));
    vecs.push_back(mk(1'b1, 12'h20A, 16'h8125, 1'b0, 12'h000, 1'b0, 4'h1, 8'hFF));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b0, 4'hF, 8'h00));
    vecs.push_back(mk(1'b1, 12'h20C, 16'h6A02, 1'b0, 12'h000, 1'b0, 4'hA, 8'h02));
    vecs.push_back(mk(1'b1, 12'h20E, 16'h3A02, 1'b0, 12'h000, 1'b0, 4'hA, 8'h02));
    vecs.push_back(mk(1'b1, 12'h210, 16'h6A55, 1'b0, 12'h000, 1'b0, 4'hA, 8'h02));
    vecs.push_back(mk(1'b1, 12'h212, 16'h6A03, 1'b0, 12'h000, 1'b0, 4'hA, 8'h03));
    vecs.push_back(mk(1'b1, 12'h214, 16'h3A02, 1'b0, 12'h000, 1'b0, 4'hA, 8'h03));
    vecs.push_back(mk(1'b1, 12'h216, 16'h6A07, 1'b0, 12'h000, 1'b0, 4'hA, 8'h07));
    vecs.push_back(mk(1'b1, 12'h218, 16'h2300, 1'b1, 12'h300, 1'b0, 4'hA, 8'h07));
    vecs.push_back(mk(1'b1, 12'h21A, 16'h6A09, 1'b0, 12'h000, 1'b0, 4'hA, 8'h07));
    vecs.push_back(mk(1'b1, 12'h300, 16'h6B44, 1'b0, 12'h000, 1'b0, 4'hB, 8'h44));
    vecs.push_back(mk(1'b1, 12'h302, 16'h00EE, 1'b1, 12'h21A, 1'b0, 4'hB, 8'h44));
    vecs.push_back(mk(1'b1, 12'h21A, 16'h6A09, 1'b0, 12'h000, 1'b0, 4'hA, 8'h09));
    vecs.push_back(mk(1'b1, 12'h21C, 16'h6381, 1'b0, 12'h000, 1'b0, 4'h3, 8'h81));
    vecs.push_back(mk(1'b1, 12'h21E, 16'h6402, 1'b0, 12'h000, 1'b0, 4'h4, 8'h02));
    vecs.push_back(mk(1'b1, 12'h220, 16'h8346, 1'b0, 12'h000, 1'b0, 4'h3, shr_v3));
    vecs.push_back(mk(1'b0, 12'h000, 16'h0000, 1'b0, 12'h000, 1'b0, 4'hF, shr_vf));
    vecs.push_back(mk(1'b1, 12'h222, 16'hC012, 1'b1 & 1'b0, 12'h000, 1'b1, 4'hA, 8'h09));
    vecs.push_back(mk(1'b1, 12'h224, 16'h8128, 1'b0, 12'h000, 1'b1, 4'h1, 8'hFF));
    vecs.push_back(mk(1'b1, 12'h226, 16'hA123, 1'b0, 12'h000, 1'b0, 4'h0, 8'h00));
    vecs.push_back(mk(1'b1, 12'h228, 16'h6010, 1'b0, 12'h000, 1'b0, 4'h0, 8'h10));
    vecs.push_back(mk(1'b1, 12'h22A, 16'hB1F8, 1'b1, 12'h208, 1'b0, 4'h0, 8'h10));
    vecs.push_back(mk(1'b1, 12'h208, 16'h8127, 1'b0, 12'h000, 1'b0, 4'h1, 8'h02));
    vecs.push_back(mk(1'b1, 12'h20A, 16'h1FFE, 1'b1, 12'hFFE, 1'b0, 4'h1, 8'h02));
    vecs.push_back(mk(1'b1, 12'hFFE, 16'h6C01, 1'b0, 12'h000, 1'b0, 4'hC, 8'h01));
    vecs.push_back(mk(1'b1, 12'h000, 16'h6C02, 1'b0, 12'h000, 1'b0, 4'hC, 8'h02));
    vecs.push_back(mk(1'b1, 12'h002, 16'h6FF0, 1'b0, 12'h000, 1'b0, 4'hF, 8'hF0));
    vecs.push_back(mk(1'b1, 12'h004, 16'h6501, 1'b0, 12'h000, 1'b0, 4'h5, 8'h01));
    vecs.push_back(mk(1'b1, 12'h006, 16'h8F54, 1'b0, 12'h000, 1'b0, 4'hF, 8'h00));
    vecs.push_back(mk(1'b1, 12'h008, 16'h2400, 1'b1, 12'h400, 1'b0, 4'hF, 8'h00));
    vecs.push_back(mk(1'b1, 12'h400, 16'h2500, 1'b1, 12'h500, 1'b0, 4'hF, 8'h00));

    rst_n = 1'b0; in_valid = 1'b0; in_pc = 12'h000; in_instr = 16'h0000; dbg_sel = 4'hA;
    last_rpc = 12'h000;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ready", {31'd0, in_ready}, 32'd0);
    chk("reset_redir", {31'd0, redirect_valid}, 32'd0);
    chk("reset_rpc", {20'd0, redirect_pc}, 32'd0);
    chk("reset_halted", {31'd0, halted}, 32'd0);
    chk("reset_i", {20'd0, i_reg}, 32'd0);
    chk("reset_VA", {24'd0, dbg_data}, 32'd0);
    rst_n = 1'b1;
    #1;
    chk("ready_after_reset", {31'd0, in_ready}, 32'd1);

    foreach (vecs[i]) apply(vecs[i], i);
    chk("i_reg", {20'd0, i_reg}, 32'h123);

    // Third nested call overflows the 2-entry stack.
    in_valid = 1'b1; in_pc = 12'h500; in_instr = 16'h2600;
    @(posedge clk); #1;
    chk("ovf_redir", {31'd0, redirect_valid}, 32'd0);
    chk("ovf_halted", {31'd0, halted}, 32'd1);
    for (int c = 0; c < 3; c++) begin
      chk("halt_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    chk("halt_sticky", {31'd0, halted}, 32'd1);

    // Reset with a matching beat presented: the beat must not execute.
    in_pc = 12'h200; in_instr = 16'h6A33; dbg_sel = 4'hA;
    do_reset();
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_VA", {24'd0, dbg_data}, 32'd0);
    chk("rst_i", {20'd0, i_reg}, 32'd0);
    @(posedge clk); #1;
    chk("rst_beat_dropped", {24'd0, dbg_data}, 32'd0);

    // Return with an empty stack faults.
    in_valid = 1'b1; in_pc = 12'h200; in_instr = 16'h00EE;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("unf_halted", {31'd0, halted}, 32'd1);
    chk("unf_redir", {31'd0, redirect_valid}, 32'd0);
    chk("unf_ready", {31'd0, in_ready}, 32'd0);
    do_reset();
    chk("unf_clear", {31'd0, halted}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
